// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, bubble word and fetch-state enum for the 16-bit core
package cpu_pkg;

  localparam logic [3:0]  OP_B      = 4'hC;
  localparam logic [3:0]  OP_BR     = 4'hD;
  localparam logic [3:0]  OP_PCS    = 4'hE;
  localparam logic [3:0]  OP_HLT    = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } fetch_state_e;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: instruction memory, hazard/branch inputs, IF/ID outputs
interface if_stage_if;

  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        flush;
  logic [15:0] branch_target;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  modport master (
    output imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted,
    input  imem_data, stall, flush, branch_target
  );

  modport slave (
    input  imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted,
    output imem_data, stall, flush, branch_target
  );

endinterface

// File: rtl/halt_ctrl.sv
// rtl/halt_ctrl.sv - halt FSM and drain counter for the fetch stage
module halt_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hlt_captured,
  input  logic flush,
  input  logic stall,
  output logic pc_freeze,
  output logic inject_bubble,
  output logic halted
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  fetch_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (hlt_captured) begin
          state_d = HALT_PEND;
          cnt_d   = DRAIN_LOAD;
        end
      end
      HALT_PEND: begin
        // A flush means the HLT was speculative; drop it and resume fetching.
        if (flush) begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end else if (!stall) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = HALTED;
        end
      end
      HALTED: ;
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign pc_freeze     = (state_q != RUN);
  assign inject_bubble = (state_q == HALTED) || ((state_q == HALT_PEND) && !stall);
  assign halted        = (state_q == HALTED);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, IF/ID register, redirect, stall and halt handling
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  if_stage_if.master    bus
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;

  logic pc_freeze, inject_bubble, halted;
  logic hlt_captured;

  // Only a normal advance in RUN can capture a HLT; flush or stall discards it.
  assign hlt_captured = !pc_freeze && !bus.flush && !bus.stall &&
                        (bus.imem_data[15:12] == OP_HLT);

  halt_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_halt_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .hlt_captured  (hlt_captured),
    .flush         (bus.flush),
    .stall         (bus.stall),
    .pc_freeze     (pc_freeze),
    .inject_bubble (inject_bubble),
    .halted        (halted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (bus.flush && !halted) begin
      pc_d       = bus.branch_target & 16'hFFFE;
      instr_d    = NOP_INSTR;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (pc_freeze) begin
      if (inject_bubble) begin
        instr_d    = NOP_INSTR;
        pc_plus2_d = 16'h0000;
        valid_d    = 1'b0;
      end
    end else if (!bus.stall) begin
      pc_d       = pc_inc(pc_q);
      instr_d    = bus.imem_data;
      pc_plus2_d = pc_inc(pc_q);
      valid_d    = 1'b1;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus2 = pc_plus2_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.halted         = halted;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - vector table, directed corner sequences and randomized model check for if_stage
module tb_if_stage;

  localparam int D = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage #(.RESET_PC(16'h0000), .DRAIN_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        stall_i = 1'b0, flush_i = 1'b0, use_mem = 1'b0;
  logic [15:0] bt_i = 16'h0, data_i = 16'h0;
  logic [15:0] mem [128];

  assign bus.stall         = stall_i;
  assign bus.flush         = flush_i;
  assign bus.branch_target = bt_i;
  always_comb bus.imem_data = use_mem ? mem[bus.imem_addr[7:1]] : data_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] a, input logic [15:0] i,
                         input logic [15:0] p, input logic v, input logic h);
    chk({tag, " addr"},  bus.imem_addr, a);
    chk({tag, " instr"}, bus.if_id_instr, i);
    chk({tag, " pc+2"},  bus.if_id_pc_plus2, p);
    chk({tag, " valid"}, {15'd0, bus.if_id_valid}, {15'd0, v});
    chk({tag, " halted"}, {15'd0, bus.halted}, {15'd0, h});
  endtask

  // Behavioural reference: mode 0 fetching, 1 draining, 2 halted; drain_left counts remaining unstalled cycles.
  logic [15:0] m_pc, m_instr, m_pp2;
  logic        m_valid;
  int          m_mode, drain_left;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0; m_pp2 = 16'h0; m_valid = 1'b0;
    m_mode = 0; drain_left = 0;
  endtask

  task automatic model_bubble();
    m_instr = 16'h0; m_pp2 = 16'h0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic [15:0] bt,
                            input logic [15:0] word);
    if (m_mode == 2) begin
      model_bubble();
    end else if (fl) begin
      m_pc = {bt[15:1], 1'b0};
      model_bubble();
      m_mode = 0;
      drain_left = 0;
    end else if (m_mode == 1) begin
      if (!st) begin
        model_bubble();
        drain_left = drain_left - 1;
        if (drain_left == 0) m_mode = 2;
      end
    end else if (!st) begin
      m_instr = word;
      m_pp2   = 16'((int'(m_pc) + 2) % 65536);
      m_valid = 1'b1;
      m_pc    = m_pp2;
      if (word[15:12] == 4'hF) begin
        m_mode = 1;
        drain_left = D;
      end
    end
  endtask

  task automatic set_in(input logic st, input logic fl, input logic [15:0] bt,
                        input logic [15:0] d);
    stall_i = st; flush_i = fl; bt_i = bt; data_i = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] bt;
    logic [15:0] data;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pp2;
    logic        e_valid;
    logic        e_halt;
  } vec_t;

  vec_t tbl[22];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0123, 16'h0002, 16'h0123, 16'h0002, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0123, 16'h0004, 16'h0123, 16'h0004, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0123, 16'h0006, 16'h0123, 16'h0006, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h1111, 16'h0008, 16'h1111, 16'h0008, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 16'h2222, 16'h0008, 16'h1111, 16'h0008, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h2222, 16'h0008, 16'h1111, 16'h0008, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 16'h3333, 16'h000A, 16'h3333, 16'h000A, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'h4444, 16'h000C, 16'h4444, 16'h000C, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h5555, 16'h000E, 16'h5555, 16'h000E, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h6666, 16'h0010, 16'h6666, 16'h0010, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h0041, 16'h7777, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h8888, 16'h0042, 16'h8888, 16'h0042, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 16'h0100, 16'hF000, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 16'h9999, 16'h0102, 16'h9999, 16'h0102, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 16'h0201, 16'h9999, 16'h0200, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0202, 16'hF000, 16'h0202, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 16'h0000, 16'hAAAA, 16'h0202, 16'hF000, 16'h0202, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 16'hAAAA, 16'h0202, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 16'h0000, 16'hAAAA, 16'h0202, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 16'h0000, 16'hAAAA, 16'h0202, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 1'b1, 16'h0300, 16'h1234, 16'h0202, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0202, 16'h0000, 16'h0000, 1'b0, 1'b1};

    // Reset values.
    do_reset();
    chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Vector table from reset through redirect, stall, discarded HLT and full halt.
    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].stall, tbl[i].flush, tbl[i].bt, tbl[i].data);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_pp2,
              tbl[i].e_valid, tbl[i].e_halt);
    end

    // Asynchronous reset out of HALTED, checked before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst_halted", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // PC wrap at 16'hFFFE.
    set_in(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    tick();
    chk("wrap target", bus.imem_addr, 16'hFFFE);
    set_in(1'b0, 1'b0, 16'h0000, 16'h0456);
    tick();
    chk_all("wrap", 16'h0000, 16'h0456, 16'h0000, 1'b1, 1'b0);

    // HLT cancelled by flush during drain.
    do_reset();
    set_in(1'b0, 1'b0, 16'h0000, 16'hF000);
    tick();
    chk_all("pend_hlt", 16'h0002, 16'hF000, 16'h0002, 1'b1, 1'b0);
    set_in(1'b0, 1'b1, 16'h0020, 16'hF000);
    tick();
    chk_all("pend_flush", 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < D + 2; k++) begin
      tick();
      chk_all($sformatf("pend_run%0d", k), 16'h0022 + 16'(2 * k), 16'h0000,
              16'h0022 + 16'(2 * k), 1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of HALT_PEND.
    set_in(1'b0, 1'b0, 16'h0000, 16'hF000);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst_pend", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 16'h0000, 16'h0777);
    for (int k = 0; k < D + 1; k++) begin
      tick();
      chk({"post_rst halted"}, {15'd0, bus.halted}, 16'h0000);
    end

    // Randomized episodes against the reference model, fetching from a random memory.
    use_mem = 1'b1;
    for (int ep = 0; ep < 25; ep++) begin
      for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
      do_reset();
      for (int c = 0; c < 40; c++) begin
        logic [15:0] word;
        set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 16'($urandom), 16'h0);
        word = mem[m_pc[7:1]];
        model_step(stall_i, flush_i, bt_i, word);
        tick();
        chk_all($sformatf("rnd e%0d c%0d", ep, c), m_pc, m_instr, m_pp2, m_valid, m_mode == 2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipelined core. Holds the PC, drives the instruction-memory address, and registers the fetched word with its PC+2 into the IF/ID pipeline register. The decode-stage control-signal decoder reads opcode bits [15:12] from this register. The stage also owns the halt sequence: HLT detection, pipeline drain, and the final `halted` flag. It honours stall requests from the hazard unit and redirect/flush requests from branch resolution.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000, PC value on reset.
- `DRAIN_CYCLES`, default 3, number of cycles between HLT entering IF/ID and `halted` asserting. Range 1–15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  16  current PC; combinational from the PC register.
- `imem_data`  in  16  instruction word; combinational read of `imem_addr`, valid in the same cycle.
- `stall`  in  1  hazard unit request: hold PC and IF/ID.
- `flush`  in  1  taken branch (B/BR) resolved in decode.
- `branch_target`  in  16  redirect PC; sampled only when `flush`=1.
- `if_id_instr`  out  16  registered instruction.
- `if_id_pc_plus2`  out  16  registered fetch PC + 2; used for the PCS write-back.
- `if_id_valid`  out  1  IF/ID holds a real instruction. Decode gates RegWrite, MemWrite and Branch with it.
- `halted`  out  1  core halted; sticky until reset.

## Operation
- States: RUN, HALT_PEND, HALTED. State encoding is internal.
- RUN:
  - If `flush`: PC ← `branch_target`, IF/ID ← bubble.
  - Else if `stall`: PC and IF/ID hold.
  - Else: PC ← PC+2, IF/ID ← {`imem_data`, PC+2, valid=1}.
  - If the captured word has opcode 4'hF, next state is HALT_PEND and the drain counter loads `DRAIN_CYCLES`.
- HALT_PEND:
  - PC frozen and `imem_addr` held.
  - IF/ID ← bubble every cycle unless `stall`=1; during a stall the HLT stays in IF/ID.
  - The counter decrements only when `stall`=0. At 1→0 the next state is HALTED.
  - If `flush`, the HLT was on the wrong path: cancel, PC ← `branch_target`, IF/ID ← bubble, return to RUN.
- HALTED: PC frozen, IF/ID holds bubble, `halted`=1. `flush` and `stall` are ignored. Only `rst_n` exits this state.
- Bubble is `if_id_instr`=16'h0000, `if_id_pc_plus2`=16'h0000, `if_id_valid`=0.
- Priority when signals coincide: reset > `flush` > `stall` > normal advance.
- Arithmetic: PC+2 is an unsigned 16-bit add that wraps; 16'hFFFE+2 = 16'h0000. `branch_target` bit 0 is forced to 0.
- An HLT fetched in the same cycle as `flush` is discarded; the FSM stays in RUN.

## Timing
- Reset (asynchronous assert, synchronous release):
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - `if_id_instr` = 16'h0000, `if_id_pc_plus2` = 16'h0000, `if_id_valid` = 0.
  - `halted` = 0, state = RUN, counter = 0.
- Fetch latency: one cycle from PC to IF/ID. Throughput is one instruction per cycle when unstalled.
- Redirect: `flush` in cycle N puts `branch_target` on `imem_addr` in cycle N+1. The target instruction is in IF/ID in N+2. Exactly one bubble is inserted.
- `stall` asserted for k cycles holds IF/ID contents and PC unchanged for exactly those k cycles. No instruction is lost or duplicated.
- Halt: HLT in IF/ID at cycle N with no stalls gives `halted`=1 in cycle N+`DRAIN_CYCLES`. Each stall cycle extends this by one.
- Reset mid-HALT_PEND or in HALTED: immediate return to the reset values above.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants `OP_B`=4'hC, `OP_BR`=4'hD, `OP_PCS`=4'hE, `OP_HLT`=4'hF;
  - `NOP_INSTR`=16'h0000;
  - fetch-state enum {RUN, HALT_PEND, HALTED}.
  - The decoder uses the same package.
- One sub-module, `halt_ctrl`: the FSM plus drain counter. Inputs: HLT-captured, `flush`, `stall`. Outputs: `pc_freeze`, `inject_bubble`, `halted`.
- PC register and the IF/ID register live in `if_stage`.

## Test plan
- Reset, then run with `imem_data` = 16'h0123 for 3 cycles:
  - `imem_addr` sequence 0000, 0002, 0004;
  - IF/ID shows {0123, 0002, valid=1} in cycle 1.
- Assert `flush` with `branch_target`=16'h0041 at PC=16'h0010:
  - next `imem_addr` = 16'h0040;
  - one bubble (valid=0);
  - then IF/ID `pc_plus2` = 16'h0042.
- `stall` high for 2 cycles at PC=16'h0008: PC and IF/ID are unchanged for both cycles, and the next advance gives PC=16'h000A.
- Start from PC=16'hFFFE, unstalled: next PC = 16'h0000, and IF/ID `pc_plus2` = 16'h0000.
- Fetch 16'hF000 with `DRAIN_CYCLES`=3:
  - bubbles follow;
  - `halted`=1 three cycles later;
  - `halted` stays 1 with `flush` pulsed;
  - `rst_n` low clears it asynchronously.
- Fetch 16'hF000, then `flush` to 16'h0020 during HALT_PEND: `halted` never asserts, the FSM is back in RUN, and `imem_addr` = 16'h0020.
